// File: rtl/aurora_reset_pkg.sv
// Shared definitions for the Aurora reset sequencer.
// - State encodings (3-bit, legacy-compatible localparams).
// - width_of(): bits needed to hold values 0..v-1. It is never less than 1,
//   so that degenerate parameters still give legal vectors.
package aurora_reset_pkg;

  localparam logic [2:0] ST_GT_RST       = 3'd0;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK    = 3'd2;
  localparam logic [2:0] ST_SYS_HOLD     = 3'd3;
  localparam logic [2:0] ST_RUN          = 3'd4;
  localparam logic [2:0] ST_FAIL         = 3'd5;

  function automatic int width_of(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reset_debouncer.sv
// Reset request conditioning.
// - RAW passes through a 2-flop synchroniser into a DEBOUNCE_LEN-deep shift register.
// - DB sets when the shift register is all ones and clears when it is all zeros.
//   Mixed contents hold DB, which gives the block its hysteresis.
// Ports:
// - USER_CLK: clock.
// - RESET: synchronous active-high reset.
// - RAW: asynchronous request.
// - DB: debounced request.
module reset_debouncer #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic USER_CLK,
  input  logic RESET,
  input  logic RAW,
  output logic DB
);

  logic [1:0]              sync;
  logic [DEBOUNCE_LEN-1:0] sh;

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      sync <= '0;
      sh   <= '0;
      DB   <= 1'b0;
    end else begin
      sync <= {sync[0], RAW};
      sh   <= (sh << 1) | DEBOUNCE_LEN'(sync[1]);
      if (&sh)
        DB <= 1'b1;
      else if (~|sh)
        DB <= 1'b0;
    end
  end

endmodule

// File: rtl/aurora_reset_sequencer.sv
// Reset sequencer for an N-lane Aurora 8b/10b channel.
// - Drives a minimum-width GT reset.
// - Waits for every lane plus the PLL to lock, with a timeout and bounded retry.
// - Holds SYSTEM_RESET until lock has been stable for SYS_RESET_HOLD cycles.
// - Re-sequences on lock loss or on a fresh (debounced) reset request.
// Ports:
// - USER_CLK, RESET: clock and synchronous active-high reset.
// - RESET_REQ: raw asynchronous request.
// - TX_LOCK_IN, PLL_NOT_LOCKED: lock status.
// - GT_RESET_OUT, SYSTEM_RESET: reset outputs.
// - LANE_READY: registered lane locks, valid only in RUN.
// - RETRY_COUNT, FAIL, STATE: status and debug outputs.
// All outputs are registered. They are computed from the next state, so they
// change on the same edge as the state register.
module aurora_reset_sequencer
  import aurora_reset_pkg::*;
#(
  parameter int N_LANES        = 3,
  parameter int DEBOUNCE_LEN   = 4,
  parameter int MIN_GT_RESET   = 8,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int SYS_RESET_HOLD = 4
) (
  input  logic                                USER_CLK,
  input  logic                                RESET,
  input  logic                                RESET_REQ,
  input  logic [N_LANES-1:0]                  TX_LOCK_IN,
  input  logic                                PLL_NOT_LOCKED,
  output logic                                GT_RESET_OUT,
  output logic                                SYSTEM_RESET,
  output logic [N_LANES-1:0]                  LANE_READY,
  output logic [width_of(MAX_RETRY+1)-1:0]    RETRY_COUNT,
  output logic                                FAIL,
  output logic [2:0]                          STATE
);

  localparam int MAX_A = (MIN_GT_RESET > LOCK_TIMEOUT) ? MIN_GT_RESET : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > SYS_RESET_HOLD) ? MAX_A : SYS_RESET_HOLD;
  localparam int CNT_W = width_of(MAX_C + 1);
  localparam int RC_W  = width_of(MAX_RETRY + 1);

  logic             req_db, req_db_q, req_rise, locked, timeout, enter;
  logic [2:0]       state, nstate;
  logic [CNT_W-1:0] cnt;
  logic [RC_W-1:0]  rc_n;

  reset_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
    .USER_CLK (USER_CLK),
    .RESET    (RESET),
    .RAW      (RESET_REQ),
    .DB       (req_db)
  );

  assign req_rise = req_db & ~req_db_q;
  assign locked   = (&TX_LOCK_IN) & ~PLL_NOT_LOCKED;
  assign STATE    = state;

  always_comb begin
    nstate  = state;
    rc_n    = RETRY_COUNT;
    timeout = 1'b0;
    if (req_rise) begin
      nstate = ST_GT_RST;
      rc_n   = '0;
    end else begin
      case (state)
        ST_GT_RST:
          if (cnt == CNT_W'(MIN_GT_RESET - 1))
            nstate = req_db ? ST_WAIT_RELEASE : ST_WAIT_LOCK;
        ST_WAIT_RELEASE:
          if (!req_db) nstate = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          // Lock beats a timeout that lands in the same cycle.
          if (locked)
            nstate = ST_SYS_HOLD;
          else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))
            timeout = 1'b1;
        ST_SYS_HOLD:
          if (!locked)
            timeout = 1'b1;
          else if (cnt == CNT_W'(SYS_RESET_HOLD - 1))
            nstate = ST_RUN;
        ST_RUN:
          // Lock loss after a good link is a fresh sequence, not a retry.
          if (!locked) begin
            nstate = ST_GT_RST;
            rc_n   = '0;
          end
        ST_FAIL: ;
        default: nstate = ST_GT_RST;
      endcase
      if (timeout) begin
        if (RETRY_COUNT == RC_W'(MAX_RETRY)) begin
          nstate = ST_FAIL;
        end else begin
          nstate = ST_GT_RST;
          rc_n   = RETRY_COUNT + RC_W'(1);
        end
      end
    end
  end

  // A request edge re-enters GT_RST even from GT_RST, so it counts as an entry.
  assign enter = (nstate != state) | req_rise;

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state        <= ST_GT_RST;
      cnt          <= '0;
      req_db_q     <= 1'b0;
      GT_RESET_OUT <= 1'b1;
      SYSTEM_RESET <= 1'b1;
      LANE_READY   <= '0;
      RETRY_COUNT  <= '0;
      FAIL         <= 1'b0;
    end else begin
      state       <= nstate;
      req_db_q    <= req_db;
      RETRY_COUNT <= rc_n;
      if (enter)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
      GT_RESET_OUT <= (nstate == ST_GT_RST) || (nstate == ST_WAIT_RELEASE);
      SYSTEM_RESET <= (nstate != ST_RUN);
      LANE_READY   <= (nstate == ST_RUN) ? TX_LOCK_IN : '0;
      FAIL         <= (nstate == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Self-checking bench for aurora_reset_sequencer.
// - Each cycle, cyc() drives the inputs and pushes the expected outputs to a queue.
// - After the edge, cyc() pushes the observed outputs to a second queue.
// - Each test task drains both queues and compares them.
// - dut16 (LOCK_TIMEOUT=16) is observed only in the FAIL scenario.
module tb_aurora_reset_sequencer;
  import aurora_reset_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       gt;
    logic       sys;
    logic [2:0] lane;
    logic [1:0] rc;
    logic       fl;
  } obs_t;

  logic       USER_CLK = 1'b0;
  logic       RESET, RESET_REQ, PLL_NOT_LOCKED;
  logic [2:0] TX_LOCK_IN;

  logic       gt_a, sys_a, fl_a, gt_b, sys_b, fl_b;
  logic [2:0] lane_a, st_a, lane_b, st_b;
  logic [1:0] rc_a, rc_b;

  obs_t  exp_q[$], obs_q[$];
  string tag_q[$];
  int    checks = 0, errors = 0;
  bit    sel16 = 1'b0;

  always #5 USER_CLK = ~USER_CLK;

  aurora_reset_sequencer dut (
    .USER_CLK(USER_CLK), .RESET(RESET), .RESET_REQ(RESET_REQ),
    .TX_LOCK_IN(TX_LOCK_IN), .PLL_NOT_LOCKED(PLL_NOT_LOCKED),
    .GT_RESET_OUT(gt_a), .SYSTEM_RESET(sys_a), .LANE_READY(lane_a),
    .RETRY_COUNT(rc_a), .FAIL(fl_a), .STATE(st_a)
  );

  aurora_reset_sequencer #(.LOCK_TIMEOUT(16)) dut16 (
    .USER_CLK(USER_CLK), .RESET(RESET), .RESET_REQ(RESET_REQ),
    .TX_LOCK_IN(TX_LOCK_IN), .PLL_NOT_LOCKED(PLL_NOT_LOCKED),
    .GT_RESET_OUT(gt_b), .SYSTEM_RESET(sys_b), .LANE_READY(lane_b),
    .RETRY_COUNT(rc_b), .FAIL(fl_b), .STATE(st_b)
  );

  // Drive one cycle of stimulus and queue the expected and observed outputs.
  // The expected output flags follow from the expected state.
  task automatic cyc(input logic r, input logic rq, input logic [2:0] lk, input logic pll,
                     input logic [2:0] est, input logic [1:0] erc, input string tag);
    obs_t e, o;
    RESET = r; RESET_REQ = rq; TX_LOCK_IN = lk; PLL_NOT_LOCKED = pll;
    e.st   = est;
    e.gt   = (est == ST_GT_RST) || (est == ST_WAIT_RELEASE);
    e.sys  = (est != ST_RUN);
    e.lane = (est == ST_RUN) ? lk : 3'b000;
    e.rc   = erc;
    e.fl   = (est == ST_FAIL);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge USER_CLK); #1;
    if (sel16) o = '{st_b, gt_b, sys_b, lane_b, rc_b, fl_b};
    else       o = '{st_a, gt_a, sys_a, lane_a, rc_a, fl_a};
    obs_q.push_back(o);
  endtask

  // Nominal bring-up after a GT_RST entry cycle: GT_RST 1..7, WAIT_LOCK 8, SYS_HOLD 9..12, RUN 13..16.
  task automatic boot_seq(input string tag);
    logic [2:0] st;
    for (int k = 1; k <= 16; k++) begin
      st = (k < 8) ? ST_GT_RST : (k == 8) ? ST_WAIT_LOCK : (k < 13) ? ST_SYS_HOLD : ST_RUN;
      cyc(1'b0, 1'b0, 3'b111, 1'b0, st, 2'd0, tag);
    end
  endtask

  task automatic test_reset;
    obs_t e, o; string t;
    cyc(1'b1, 1'b0, 3'b111, 1'b0, ST_GT_RST, 2'd0, "reset_values");
    boot_seq("boot");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  task automatic test_lock_loss;
    obs_t e, o; string t;
    cyc(1'b0, 1'b0, 3'b101, 1'b0, ST_GT_RST, 2'd0, "lock_loss");
    boot_seq("reboot");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  task automatic test_req_debounce;
    obs_t e, o; string t; logic [2:0] st;
    for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, 3'b111, 1'b0, ST_RUN, 2'd0, "req_short");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 3'b111, 1'b0, ST_RUN, 2'd0, "req_short_idle");
    // GT_RESET_OUT rises 7 edges after the first high sample and is held in WAIT_RELEASE.
    for (int i = 0; i < 20; i++) begin
      st = (i < 7) ? ST_RUN : (i < 15) ? ST_GT_RST : ST_WAIT_RELEASE;
      cyc(1'b0, 1'b1, 3'b111, 1'b0, st, 2'd0, "req_long");
    end
    for (int i = 0; i < 13; i++) begin
      st = (i < 7) ? ST_WAIT_RELEASE : (i == 7) ? ST_WAIT_LOCK : (i < 12) ? ST_SYS_HOLD : ST_RUN;
      cyc(1'b0, 1'b0, 3'b111, 1'b0, st, 2'd0, "req_release");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  task automatic test_retry;
    obs_t e, o; string t;
    cyc(1'b1, 1'b0, 3'b111, 1'b0, ST_GT_RST, 2'd0, "retry_reset");
    for (int k = 1; k <= 8; k++)
      cyc(1'b0, 1'b0, 3'b111, 1'b0, (k < 8) ? ST_GT_RST : ST_WAIT_LOCK, 2'd0, "retry_boot");
    cyc(1'b0, 1'b0, 3'b111, 1'b0, ST_SYS_HOLD, 2'd0, "retry_hold");
    // One PLL glitch in SYS_HOLD consumes a retry.
    cyc(1'b0, 1'b0, 3'b111, 1'b1, ST_GT_RST, 2'd1, "hold_drop");
    for (int k = 1; k <= 8; k++)
      cyc(1'b0, 1'b0, 3'b011, 1'b0, (k < 8) ? ST_GT_RST : ST_WAIT_LOCK, 2'd1, "retry_gt");
    for (int k = 0; k < 1023; k++)
      cyc(1'b0, 1'b0, 3'b011, 1'b0, ST_WAIT_LOCK, 2'd1, "wait_lock");
    // Lock arrives on the timeout edge: lock wins, no retry consumed.
    cyc(1'b0, 1'b0, 3'b111, 1'b0, ST_SYS_HOLD, 2'd1, "lock_on_timeout");
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 3'b111, 1'b0, ST_SYS_HOLD, 2'd1, "retry_hold2");
    cyc(1'b0, 1'b0, 3'b111, 1'b0, ST_RUN, 2'd1, "retry_run");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t e, o; string t;
    cyc(1'b1, 1'b0, 3'b000, 1'b0, ST_GT_RST, 2'd0, "mid_reset0");
    for (int k = 1; k <= 20; k++)
      cyc(1'b0, 1'b0, 3'b000, 1'b0, (k < 8) ? ST_GT_RST : ST_WAIT_LOCK, 2'd0, "mid_wait");
    cyc(1'b1, 1'b0, 3'b000, 1'b0, ST_GT_RST, 2'd0, "mid_reset");
    boot_seq("mid_boot");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  // LOCK_TIMEOUT=16: each attempt is 8 GT_RST + 16 WAIT_LOCK cycles.
  // The fourth timeout, on edge 96, lands in FAIL.
  task automatic test_fail;
    obs_t e, o; string t; logic [2:0] st; logic [1:0] rc;
    sel16 = 1'b1;
    cyc(1'b1, 1'b0, 3'b011, 1'b0, ST_GT_RST, 2'd0, "fail_reset");
    for (int k = 1; k <= 104; k++) begin
      if (k >= 96) begin
        st = ST_FAIL; rc = 2'd3;
      end else begin
        st = ((k % 24) < 8) ? ST_GT_RST : ST_WAIT_LOCK;
        rc = 2'(k / 24);
      end
      cyc(1'b0, 1'b0, 3'b011, 1'b0, st, rc, "timeouts");
    end
    for (int i = 0; i < 16; i++) begin
      st = (i < 7) ? ST_FAIL : (i < 15) ? ST_GT_RST : ST_WAIT_RELEASE;
      cyc(1'b0, 1'b1, 3'b011, 1'b0, st, (i < 7) ? 2'd3 : 2'd0, "fail_exit_req");
    end
    sel16 = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b, want st=%0d gt=%b sys=%b lane=%b rc=%0d fail=%b",
                 t, o.st, o.gt, o.sys, o.lane, o.rc, o.fl, e.st, e.gt, e.sys, e.lane, e.rc, e.fl);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; RESET_REQ = 1'b0; TX_LOCK_IN = 3'b111; PLL_NOT_LOCKED = 1'b0;
    test_reset();
    test_lock_loss();
    test_req_debounce();
    test_retry();
    test_reset_mid();
    test_fail();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
